// File: rtl/fifo_rd_stream_pkg.sv
// Shared helpers for the FIFO read-side stream stage.
package fifo_rd_stream_pkg;

  // The queue depth can be 3, so pointers wrap by compare-and-reset rather than by bit truncation.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
    return (idx + 1 == depth) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// DEPTH-entry circular register queue with push/pop, a count, and a registered head word.
module fifo_rd_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int DEPTH = 2
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic                     push,
  input  logic [DSIZE-1:0]         push_data,
  input  logic                     pop,
  output logic [DSIZE-1:0]         head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt, remaining;
  logic [DSIZE-1:0] head_nxt;
  logic             pop_eff;

  assign pop_eff = pop && (count != '0);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    head_nxt   = head;
    if (push)    wr_ptr_nxt = PW'(wrap_inc(32'(wr_ptr), DEPTH));
    if (pop_eff) rd_ptr_nxt = PW'(wrap_inc(32'(rd_ptr), DEPTH));
    remaining = count - CW'(pop_eff);
    count_nxt = remaining + CW'(push);
    // Head register tracks the oldest surviving word; a word entering an empty queue loads it directly.
    if (remaining != '0) head_nxt = mem[rd_ptr_nxt];
    else if (push)       head_nxt = push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      assert (!(push && !pop_eff && count == CW'(DEPTH))) else $error("fifo_rd_buf overflow");
      assert (!(pop && count == '0)) else $error("fifo_rd_buf underflow");
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
    end
  end

  // NOTE: storage entries are not reset; count gates every read of them, so reset cost buys nothing.
  always_ff @(posedge rclk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side stream stage: prefetches from the FIFO memory into a small queue and presents a registered valid/ready stream.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE      = 8,
  parameter int RD_LATENCY = 0
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       occupancy
);

  localparam int D = 2 + RD_LATENCY;

  logic [1:0] count;
  logic [2:0] pending;
  logic       inflight;
  logic       push;

  // Reserve a slot for every word still travelling through the memory read pipeline.
  assign pending = 3'(count) + 3'(inflight);
  assign rinc    = !rempty && (pending < 3'(D));

  if (RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) inflight <= 1'b0;
      else         inflight <= rinc;
    end
    assign push = inflight;
  end else if (RD_LATENCY == 0) begin : g_lat0
    assign inflight = 1'b0;
    assign push     = rinc;
  end else begin : g_bad
    $error("fifo_rd_stream: RD_LATENCY must be 0 or 1");
  end

  assign m_valid   = (count != 2'd0);
  assign occupancy = count;

  fifo_rd_buf #(
    .DSIZE(DSIZE),
    .DEPTH(D)
  ) u_buf (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .push     (push),
    .push_data(rdata),
    .pop      (m_valid && m_ready),
    .head     (m_data),
    .count    (count)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: both read latencies run side by side against a queue-based FIFO/memory model.
module tb_fifo_rd_stream;

  localparam int DSIZE = 8;
  localparam int NSRC  = 16384;

  logic rclk = 1'b0;
  logic rrst_n;
  logic m_ready;

  always #5 rclk = ~rclk;

  logic [DSIZE-1:0] src [NSRC];
  int wr_cnt;
  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_word(input logic [DSIZE-1:0] val);
    src[wr_cnt] = val;
    wr_cnt++;
  endtask

  for (genvar l = 0; l < 2; l++) begin : lane
    logic             rempty;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic [1:0]       occupancy;
    logic [DSIZE-1:0] exp_q [$];
    int               rd_idx;
    int               pushed;
    int               beats;

    fifo_rd_stream #(.DSIZE(DSIZE), .RD_LATENCY(l)) dut (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .rempty   (rempty),
      .rinc     (rinc),
      .rdata    (rdata),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .occupancy(occupancy)
    );

    // Upstream FIFO + memory: registered empty flag, read data combinational (l=0) or one cycle late (l=1).
    initial begin
      logic rinc_s;
      rempty = 1'b1;
      rdata  = '0;
      rd_idx = 0;
      pushed = 0;
      forever begin
        @(negedge rclk);
        rinc_s = rinc;
        if (rrst_n && rempty) check($sformatf("L%0d rinc_while_empty", l), rinc, 0);
        @(posedge rclk);
        #1;
        if (!rrst_n) begin
          rd_idx = wr_cnt;
          pushed = wr_cnt;
          exp_q.delete();
          rempty = 1'b1;
        end else begin
          while (pushed < wr_cnt) begin
            exp_q.push_back(src[pushed]);
            pushed++;
          end
          if (rinc_s) begin
            if (l == 1) rdata = src[rd_idx];
            rd_idx++;
          end
          rempty = (rd_idx >= wr_cnt);
          if (l == 0) rdata = src[rd_idx];
        end
      end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks the hold rule under backpressure.
    initial begin
      logic             hold;
      logic [DSIZE-1:0] hold_data;
      hold  = 1'b0;
      beats = 0;
      forever begin
        @(negedge rclk);
        if (!rrst_n) begin
          hold  = 1'b0;
          beats = 0;
        end else begin
          if (hold) begin
            check($sformatf("L%0d hold_valid", l), m_valid, 1);
            check($sformatf("L%0d hold_data", l), m_data, hold_data);
          end
          if (m_valid && m_ready) begin
            beats++;
            if (exp_q.size() == 0) check($sformatf("L%0d unexpected_word", l), 1, 0);
            else                   check($sformatf("L%0d order", l), m_data, exp_q.pop_front());
          end
          hold      = m_valid && !m_ready;
          hold_data = m_data;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " L0 m_valid"}, lane[0].m_valid, 0);
    check({tag, " L0 m_data"}, lane[0].m_data, 0);
    check({tag, " L0 occupancy"}, lane[0].occupancy, 0);
    check({tag, " L1 m_valid"}, lane[1].m_valid, 0);
    check({tag, " L1 m_data"}, lane[1].m_data, 0);
    check({tag, " L1 occupancy"}, lane[1].occupancy, 0);
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int c;
    c = 0;
    while ((lane[0].exp_q.size() != 0 || lane[1].exp_q.size() != 0) && c < budget) begin
      @(negedge rclk);
      c++;
    end
    check({tag, " L0 leftover"}, lane[0].exp_q.size(), 0);
    check({tag, " L1 leftover"}, lane[1].exp_q.size(), 0);
  endtask

  initial begin
    logic [DSIZE-1:0] first_bp;
    int               phase_len;
    logic             phase_on;
    int               written;
    int               c;

    vectors     = 0;
    miscompares = 0;
    wr_cnt      = 0;
    m_ready     = 1'b0;
    rrst_n      = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge rclk);
    #2 rrst_n = 1'b1;

    // Idle with an empty FIFO: nothing moves.
    repeat (20) begin
      @(negedge rclk);
      check_reset_outputs("idle");
      check("idle L0 rinc", lane[0].rinc, 0);
      check("idle L1 rinc", lane[1].rinc, 0);
    end

    // Streaming 0x01..0x10 with m_ready high; j counts edges after rempty falls.
    @(posedge rclk);
    #2;
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) write_word(DSIZE'(i));
    @(negedge rclk);
    for (int j = 0; j < 20; j++) begin
      @(negedge rclk);
      if (j == 0) check("stream L0 rinc_first_cycle", lane[0].rinc, 1);
      check($sformatf("stream L0 valid j=%0d", j), lane[0].m_valid, (j >= 1 && j <= 16) ? 1 : 0);
      check($sformatf("stream L1 valid j=%0d", j), lane[1].m_valid, (j >= 2 && j <= 17) ? 1 : 0);
    end
    check("stream L0 beats", lane[0].beats, 16);
    check("stream L1 beats", lane[1].beats, 16);

    // Backpressure: queue fills to its depth, prefetch stops, head holds.
    @(posedge rclk);
    #2;
    m_ready  = 1'b0;
    first_bp = DSIZE'(8'h40);
    for (int i = 0; i < 10; i++) write_word(first_bp + DSIZE'(i));
    repeat (10) @(negedge rclk);
    check("bp L0 occupancy", lane[0].occupancy, 2);
    check("bp L1 occupancy", lane[1].occupancy, 3);
    check("bp L0 rinc", lane[0].rinc, 0);
    check("bp L1 rinc", lane[1].rinc, 0);
    check("bp L0 head", lane[0].m_data, first_bp);
    check("bp L1 head", lane[1].m_data, first_bp);
    @(posedge rclk);
    #2 m_ready = 1'b1;
    wait_drained("bp", 100);

    // Random traffic: bursty producer with idle gaps, 50% consumer.
    written   = 0;
    phase_len = 0;
    phase_on  = 1'b1;
    while (written < 10000) begin
      @(posedge rclk);
      #2;
      if (phase_len == 0) begin
        phase_on  = ~phase_on;
        phase_len = $urandom_range(1, 30);
      end
      phase_len--;
      m_ready = 1'($urandom_range(0, 1));
      if (phase_on && $urandom_range(0, 9) != 0) begin
        write_word(DSIZE'($urandom));
        written++;
      end
    end
    c = 0;
    while ((lane[0].exp_q.size() != 0 || lane[1].exp_q.size() != 0) && c < 40000) begin
      @(posedge rclk);
      #2 m_ready = 1'($urandom_range(0, 1));
      c++;
    end
    check("random L0 leftover", lane[0].exp_q.size(), 0);
    check("random L1 leftover", lane[1].exp_q.size(), 0);

    // Reset with words buffered: outputs clear without a clock edge, then a fresh stream restarts.
    @(posedge rclk);
    #2;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(DSIZE'(8'hA0 + i));
    c = 0;
    do begin
      @(negedge rclk);
      c++;
    end while (lane[0].occupancy != 2 && c < 20);
    check("rst L0 occupancy_before", lane[0].occupancy, 2);
    #2 rrst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(posedge rclk);
    #2;
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_word(DSIZE'(8'hC0 + i));
    repeat (30) @(negedge rclk);
    check("restart L0 beats", lane[0].beats, 8);
    check("restart L1 beats", lane[1].beats, 8);
    wait_drained("restart", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
